// File: rtl/ls_mem_unit.sv
// ---------------------------------------------------------------------------
// ls_mem_unit
//
// Local-store responder for the odd-pipe load/store path. It holds the
// 32 KB local store as QW_DEPTH quadwords of DATA_W bits. Stores write one
// quadword. Loads read one quadword and return it with its destination
// register LOAD_LAT cycles after the request cycle.
//
// All requests touch the array in S1, in issue order. A load issued right
// after a store to the same quadword therefore sees the new data, with no
// bypass path needed.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears control state and the
//                 response outputs; array contents are preserved
//   req_valid     request present this cycle (always accepted)
//   req_is_store  1 = store, 0 = load
//   req_addr      byte address [0:14]; only [0:10] selects the quadword
//   req_rt        load destination register
//   req_st_data   store data [0:127]
//   flush         kills every in-flight load and the request of this cycle
//   rsp_valid     load data valid this cycle
//   rsp_data      returned quadword (holds when rsp_valid = 0)
//   rsp_rt        destination register of the returned load
//   st_done       one-cycle pulse: a store committed to the array
// ---------------------------------------------------------------------------
module ls_mem_unit #(
  parameter int LOAD_LAT = 6,     // legal range 2..8
  parameter int QW_DEPTH = 2048,
  parameter int DATA_W   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [0:14]       req_addr,
  input  logic [0:6]        req_rt,
  input  logic [0:DATA_W-1] req_st_data,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [0:DATA_W-1] rsp_data,
  output logic [0:6]        rsp_rt,
  output logic              st_done
);

  localparam int IDX_W = $clog2(QW_DEPTH);
  // Registered stages ahead of the output stage (S1 .. S(LOAD_LAT-1)).
  localparam int MID   = LOAD_LAT - 1;

  logic [0:DATA_W-1] mem [QW_DEPTH];

  logic [0:IDX_W-1]  idx_p0;
  logic              acc_p0;
  logic              ld_p0;
  logic              wr_en_p0;
  logic              unused_addr_lsbs;

  logic [1:MID]      vld_p;
  logic [0:DATA_W-1] data_p [1:MID];
  logic [0:6]        rt_p   [1:MID];

  // ---- p0: request decode ----
  // The byte-in-quadword bits carry no meaning for a quadword access.
  assign idx_p0           = req_addr[0:IDX_W-1];
  assign unused_addr_lsbs = ^req_addr[IDX_W:14];

  // A flush drops the request in the same cycle. A store seen while reset
  // is high must not reach the array, even though the array has no reset.
  assign acc_p0   = req_valid & ~flush;
  assign ld_p0    = acc_p0 & ~req_is_store;
  assign wr_en_p0 = acc_p0 & req_is_store & ~reset;

  // ---- p0 -> p1: array access, then data/rt shift S1..S(LOAD_LAT-1) ----
  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      mem[idx_p0] <= req_st_data;
    end
    if (ld_p0) begin
      data_p[1] <= mem[idx_p0];
      rt_p[1]   <= req_rt;
    end
    for (int s = 2; s <= MID; s++) begin
      data_p[s] <= data_p[s-1];
      rt_p[s]   <= rt_p[s-1];
    end
  end

  // ---- control: valid shift, output valid, store pulse ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p     <= '0;
      rsp_valid <= 1'b0;
      st_done   <= 1'b0;
    end else begin
      st_done <= acc_p0 & req_is_store;
      if (flush) begin
        vld_p     <= '0;
        rsp_valid <= 1'b0;
      end else begin
        vld_p[1] <= ld_p0;
        for (int s = 2; s <= MID; s++) begin
          vld_p[s] <= vld_p[s-1];
        end
        rsp_valid <= vld_p[MID];
      end
    end
  end

  // ---- p(LOAD_LAT): output stage, holds its value between responses ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_rt   <= '0;
    end else if (vld_p[MID] && !flush) begin
      rsp_data <= data_p[MID];
      rsp_rt   <= rt_p[MID];
    end
  end

endmodule

// File: tb/tb_ls_mem_unit.sv
`timescale 1ns/1ps
module tb_ls_mem_unit;

  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_is_store = 1'b0;
  logic [0:14]  req_addr = '0;
  logic [0:6]   req_rt = '0;
  logic [0:127] req_st_data = '0;
  logic         flush = 1'b0;
  logic         rsp_valid;
  logic [0:127] rsp_data;
  logic [0:6]   rsp_rt;
  logic         st_done;

  ls_mem_unit #(.LOAD_LAT(LAT), .QW_DEPTH(2048), .DATA_W(128)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_rt(req_rt), .req_st_data(req_st_data), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rt(rsp_rt), .st_done(st_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: quadword store keyed by index, plus expected responses.
  typedef struct {
    int           due;
    logic [127:0] data;
    logic [6:0]   rt;
  } exp_t;

  exp_t         expq[$];
  exp_t         me;
  logic [127:0] mdl [int];
  bit           st_exp [int];
  int           n_cmp = 0;
  int           n_fail = 0;

  logic [127:0] xval;
  int           r;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_int(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [14:0] addr_of(int idx, int lo);
    return 15'((idx << 4) | (lo & 15));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One request cycle; updates the model in program order, then advances.
  task automatic drive(bit v, bit st, logic [14:0] addr, logic [6:0] rt,
                       logic [127:0] d, bit fl);
    int   idx;
    exp_t e;
    idx          = int'(addr[14:4]);
    req_valid    = v;
    req_is_store = st;
    req_addr     = addr;
    req_rt       = rt;
    req_st_data  = d;
    flush        = fl;
    if (fl) begin
      for (int i = expq.size() - 1; i >= 0; i--)
        if (expq[i].due > cyc) expq.delete(i);
    end else if (v) begin
      if (st) begin
        mdl[idx] = d;
        st_exp[cyc + 1] = 1'b1;
      end else begin
        e.due  = cyc + LAT;
        e.data = mdl.exists(idx) ? mdl[idx] : 128'h0;
        e.rt   = rt;
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 15'h0, 7'h0, 128'h0, 1'b0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk_int("st_done", int'(st_done), int'(st_exp.exists(cyc)));
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          chk_int("spurious_rsp_valid", 1, 0);
        end else begin
          me = expq.pop_front();
          chk_int("rsp_cycle", cyc, me.due);
          chk("rsp_data", rsp_data, me.data);
          chk("rsp_rt", 128'(rsp_rt), 128'(me.rt));
        end
      end
      while (expq.size() > 0 && expq[0].due < cyc) begin
        chk_int("missing_rsp_at_cycle", cyc, expq[0].due);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("reset_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("reset_rsp_data", rsp_data, 128'h0);
    chk("reset_rsp_rt", 128'(rsp_rt), 128'h0);
    chk("reset_st_done", 128'(st_done), 128'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Prefill indices 0..31 with their own index, plus the alignment pair.
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b1, addr_of(i, int'($urandom_range(0, 15))), 7'h0, 128'(i), 1'b0);
    drive(1'b1, 1'b1, 15'h7FE0, 7'h0, 128'h0, 1'b0);
    drive(1'b1, 1'b1, 15'h7FF0, 7'h0, 128'h0, 1'b0);

    // Back-to-back loads 0..7, rt 10..17
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, addr_of(i, 0), 7'(10 + i), 128'h0, 1'b0);
    idle(2);

    // Store then load next cycle
    drive(1'b1, 1'b1, 15'h0040, 7'h0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    drive(1'b1, 1'b0, 15'h0040, 7'd5, 128'h0, 1'b0);
    idle(2);

    // Alignment
    drive(1'b1, 1'b1, 15'h7FF0, 7'h0, {128{1'b1}}, 1'b0);
    drive(1'b1, 1'b0, 15'h7FFF, 7'd127, 128'h0, 1'b0);
    drive(1'b1, 1'b0, 15'h7FE0, 7'd1, 128'h0, 1'b0);
    idle(2);

    // Load/store same address
    drive(1'b1, 1'b1, 15'h0100, 7'h0, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666, 1'b0);
    drive(1'b1, 1'b0, 15'h0100, 7'd20, 128'h0, 1'b0);
    drive(1'b1, 1'b1, 15'h0100, 7'h0, 128'hBBBB_7777_8888_9999_AAAA_CCCC_DDDD_EEEE, 1'b0);
    drive(1'b1, 1'b0, 15'h0100, 7'd21, 128'h0, 1'b0);
    idle(LAT + 2);

    // Flush: three loads, flush in the third load's cycle, then a fresh load
    drive(1'b1, 1'b0, addr_of(1, 3), 7'd30, 128'h0, 1'b0);
    drive(1'b1, 1'b0, addr_of(2, 3), 7'd31, 128'h0, 1'b0);
    drive(1'b1, 1'b0, addr_of(3, 3), 7'd32, 128'h0, 1'b1);
    drive(1'b1, 1'b0, addr_of(6, 0), 7'd33, 128'h0, 1'b0);
    idle(LAT + 2);

    // Randomized traffic over indices 0..31
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      drive(r < 80, ($urandom % 3) == 0, addr_of(int'($urandom_range(0, 31)), int'($urandom_range(0, 15))),
            7'($urandom), rnd128(), ($urandom % 25) == 0);
    end
    idle(LAT + 2);
    chk_int("queue_drained", expq.size(), 0);

    // Reset mid-operation
    xval = rnd128() | 128'h1;
    drive(1'b1, 1'b1, addr_of(3, 7), 7'h0, xval, 1'b0);
    drive(1'b1, 1'b0, addr_of(3, 0), 7'd40, 128'h0, 1'b0);
    idle(LAT + 1);
    drive(1'b1, 1'b0, addr_of(3, 0), 7'd41, 128'h0, 1'b0);
    drive(1'b1, 1'b0, addr_of(5, 0), 7'd42, 128'h0, 1'b0);
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("midreset_rsp_data", rsp_data, 128'h0);
    chk("midreset_rsp_rt", 128'(rsp_rt), 128'h0);
    chk("midreset_st_done", 128'(st_done), 128'h0);
    expq.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    idle(LAT + 2);

    // Data survives reset
    drive(1'b1, 1'b0, addr_of(3, 9), 7'd43, 128'h0, 1'b0);
    idle(LAT + 2);
    chk_int("final_queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
